// File: rtl/mem_handle_responder.sv
// Round-robin memory responder for the mem_handle request protocol (FPU parameter/gradient store).
// Define MEM_RESP_BOUNDS_EN to enforce per-client [region_begin, region_end) access windows.
`timescale 1ns/1ps
module mem_handle_responder #(
    parameter int NUM_CLIENTS = 4,
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                               clk,
    input  logic                               rst_l,
    input  logic [NUM_CLIENTS-1:0]             client_avail,
    input  logic [NUM_CLIENTS-1:0]             client_r_en,
    input  logic [NUM_CLIENTS-1:0]             client_w_en,
    input  logic [NUM_CLIENTS-1:0][31:0]       client_ptr,
    input  logic [NUM_CLIENTS-1:0][WIDTH-1:0]  client_data_store,
    input  logic [NUM_CLIENTS-1:0][31:0]       client_region_begin,
    input  logic [NUM_CLIENTS-1:0][31:0]       client_region_end,
    output logic [NUM_CLIENTS-1:0]             client_done,
    output logic [NUM_CLIENTS-1:0]             client_err,
    output logic [WIDTH-1:0]                   data_load,
    output logic                               busy
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d, rr_q, rr_d;
    logic                   wr_q, wr_d, oor_q, oor_d, rviol_q, rviol_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [NUM_CLIENTS-1:0] cool_q, cool_d;
    logic [WIDTH-1:0]       dload_q, dload_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic [NUM_CLIENTS-1:0] elig;
    logic                   grant_vld;
    logic [IW-1:0]          grant_idx, rr_j;
    logic [31:0]            gptr;
    logic                   greg_viol;
    logic                   mem_we;

    assign elig = client_avail & (client_r_en | client_w_en) & ~cool_q;

    // First eligible client at or after rr_q, wrapping modulo NUM_CLIENTS.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_j      = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            rr_j = IW'((int'(rr_q) + k) % NUM_CLIENTS);
            if (!grant_vld && elig[rr_j]) begin
                grant_vld = 1'b1;
                grant_idx = rr_j;
            end
        end
    end

    assign gptr = client_ptr[grant_idx];

`ifdef MEM_RESP_BOUNDS_EN
    assign greg_viol = (gptr < client_region_begin[grant_idx]) ||
                       (gptr >= client_region_end[grant_idx]);
`else
    logic unused_region;
    assign greg_viol     = 1'b0;
    assign unused_region = ^{client_region_begin, client_region_end};
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            rviol_q <= 1'b0;
            cnt_q   <= '0;
            cool_q  <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            oor_q   <= oor_d;
            rviol_q <= rviol_d;
            cnt_q   <= cnt_d;
            cool_q  <= cool_d;
            dload_q <= dload_d;
        end
    end

    always_ff @(posedge clk) begin
        ptr_q   <= ptr_d;
        wdata_q <= wdata_d;
    end

    // The store is not reset; an async reset forces IDLE, so a pending write never lands.
    assign mem_we = (state_q == BUSY) && (cnt_q == 4'd0) && wr_q && !oor_q && !rviol_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        wr_d    = wr_q;
        oor_d   = oor_q;
        rviol_d = rviol_q;
        cnt_d   = cnt_q;
        cool_d  = cool_q;
        dload_d = dload_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                cool_d = '0;
                if (grant_vld) begin
                    idx_d   = grant_idx;
                    wr_d    = client_w_en[grant_idx];
                    ptr_d   = gptr[AW-1:0];
                    wdata_d = client_data_store[grant_idx];
                    oor_d   = (gptr >= 32'(DEPTH));
                    rviol_d = greg_viol;
                    rr_d    = (grant_idx == IW'(NUM_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    // A region violation leaves data_load untouched; out-of-range reads return zero.
                    if (!wr_q && !rviol_q) begin
                        dload_d = oor_q ? '0 : mem_q[ptr_q];
                    end
                end
            end
            RESP: begin
                cool_d[idx_q] = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        client_done = '0;
        client_err  = '0;
        if (state_q == RESP) begin
            client_done[idx_q] = 1'b1;
            client_err[idx_q]  = oor_q | rviol_q;
        end
    end

    assign busy      = (state_q != IDLE);
    assign data_load = dload_q;

endmodule

// File: tb/tb_mem_handle_responder.sv
// Scoreboard bench for mem_handle_responder (LATENCY=4); region tests build with MEM_RESP_BOUNDS_EN.
`timescale 1ns/1ps
module tb_mem_handle_responder;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int D   = 1024;
    localparam int LAT = 4;

    logic                clk = 1'b0;
    logic                rst_l;
    logic [N-1:0]        avail, r_en, w_en;
    logic [N-1:0][31:0]  ptr, rb, re;
    logic [N-1:0][W-1:0] dst;
    logic [N-1:0]        done, err;
    logic [W-1:0]        dload;
    logic                busy;

    always #5 clk = ~clk;

    mem_handle_responder #(
        .NUM_CLIENTS(N), .WIDTH(W), .DEPTH(D), .LATENCY(LAT)
    ) u_dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .client_avail       (avail),
        .client_r_en        (r_en),
        .client_w_en        (w_en),
        .client_ptr         (ptr),
        .client_data_store  (dst),
        .client_region_begin(rb),
        .client_region_end  (re),
        .client_done        (done),
        .client_err         (err),
        .data_load          (dload),
        .busy               (busy)
    );

    typedef struct {
        int         client;
        logic       err;
        logic [W-1:0] dl;
        int         at;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model [D];
    logic [W-1:0] exp_dl;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int c, input bit wr, input logic [31:0] p,
                            input logic [W-1:0] d, input int at);
        bit   oor;
        bit   viol;
        exp_t e;
        oor  = (p >= 32'(D));
        viol = 1'b0;
`ifdef MEM_RESP_BOUNDS_EN
        viol = (p < rb[c]) || (p >= re[c]);
`endif
        if (wr) begin
            if (!oor && !viol) model[p[9:0]] = d;
        end else if (!viol) begin
            exp_dl = oor ? '0 : model[p[9:0]];
        end
        e.client = c;
        e.err    = oor | viol;
        e.dl     = exp_dl;
        e.at     = at;
        sb.push_back(e);
    endtask

    task automatic drive(input int c, input bit rd, input bit wr, input logic [31:0] p,
                         input logic [W-1:0] d);
        avail[c] = 1'b1;
        r_en[c]  = rd;
        w_en[c]  = wr;
        ptr[c]   = p;
        dst[c]   = d;
    endtask

    task automatic release_c(input int c);
        avail[c] = 1'b0;
        r_en[c]  = 1'b0;
        w_en[c]  = 1'b0;
    endtask

    // Solo request: two idle negedges first so the responder is in IDLE with cooldown clear.
    task automatic req(input int c, input bit rd, input bit wr, input logic [31:0] p,
                       input logic [W-1:0] d);
        bit got;
        got = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(c, wr, p, d, cyc + 1 + LAT);
        drive(c, rd, wr, p, d);
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (done[c]) got = 1'b1;
        end
        release_c(c);
        if (!got) check("req_timeout", 64'(0), 64'(1));
    endtask

    exp_t m_e;
    int   m_idx;
    always @(negedge clk) begin
        if (rst_l === 1'b1 && (done != '0 || err != '0)) begin
            check("err_without_done", 64'(err & ~done), 64'(0));
            check("done_onehot", 64'($countones(done)), 64'(1));
            m_idx = 0;
            for (int i = 0; i < N; i++) if (done[i]) m_idx = i;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                m_e = sb.pop_front();
                check("done_client", 64'(m_idx), 64'(m_e.client));
                check("err_flag", 64'(err[m_idx]), 64'(m_e.err));
                check("data_load", 64'(dload), 64'(m_e.dl));
                check("done_cycle", 64'(cyc), 64'(m_e.at));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0;
        int         n;
        logic [2:0] pending;
        rst_l  = 1'b0;
        avail  = '0;
        r_en   = '0;
        w_en   = '0;
        ptr    = '0;
        dst    = '0;
        rb     = '0;
        re     = {N{32'hFFFF_FFFF}};
        exp_dl = '0;
        repeat (3) @(negedge clk);
        check("reset_done", 64'(done), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_data_load", 64'(dload), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        rst_l = 1'b1;

        // Preload via client 3; its last grant wraps rr_ptr back to 0.
        req(3, 1'b0, 1'b1, 32'd0, 32'h0000_0100);
        req(3, 1'b0, 1'b1, 32'd1, 32'h0000_0101);
        req(3, 1'b0, 1'b1, 32'd2, 32'h0000_0102);
        req(3, 1'b0, 1'b1, 32'd9, 32'h0000_1111);

        // Round robin: three simultaneous reads served 0,1,2 with LAT+2 spacing.
        repeat (2) @(negedge clk);
        c0 = cyc;
        push_exp(0, 1'b0, 32'd0, '0, c0 + 1 + LAT);
        push_exp(1, 1'b0, 32'd1, '0, c0 + 3 + 2 * LAT);
        push_exp(2, 1'b0, 32'd2, '0, c0 + 5 + 3 * LAT);
        drive(0, 1'b1, 1'b0, 32'd0, '0);
        drive(1, 1'b1, 1'b0, 32'd1, '0);
        drive(2, 1'b1, 1'b0, 32'd2, '0);
        pending = 3'b111;
        for (int k = 0; k < 200 && pending != 3'b000; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done[i] && pending[i]) begin
                    pending[i] = 1'b0;
                    release_c(i);
                end
            end
        end
        check("rr_all_served", 64'(pending), 64'(0));

        req(0, 1'b0, 1'b1, 32'd5, 32'h3F80_0000);
        req(0, 1'b1, 1'b0, 32'd5, '0);
        req(2, 1'b1, 1'b1, 32'd6, 32'hA5A5_0001);
        req(3, 1'b1, 1'b0, 32'd6, '0);
        req(1, 1'b0, 1'b1, 32'd7, 32'h1234_5678);
        req(0, 1'b0, 1'b1, 32'(D + 7), 32'h0000_0BAD);
        req(1, 1'b1, 1'b0, 32'd7, '0);
        req(2, 1'b1, 1'b0, 32'(D), '0);

        // Cooldown: held request is re-served exactly LAT+3 cycles later.
        repeat (2) @(negedge clk);
        c0 = cyc;
        push_exp(1, 1'b0, 32'd5, '0, c0 + 1 + LAT);
        push_exp(1, 1'b0, 32'd5, '0, c0 + 1 + LAT + LAT + 3);
        drive(1, 1'b1, 1'b0, 32'd5, '0);
        n = 0;
        for (int k = 0; k < 100 && n < 2; k++) begin
            @(negedge clk);
            if (done[1]) n++;
        end
        release_c(1);
        check("cooldown_done_count", 64'(n), 64'(2));

        // Reset during the second BUSY cycle of a write to ptr 9.
        repeat (2) @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'd9, 32'hDEAD_BEEF);
        @(negedge clk);
        @(negedge clk);
        check("busy_before_reset", 64'(busy), 64'(1));
        rst_l = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_done", 64'(done), 64'(0));
        check("midreset_data_load", 64'(dload), 64'(0));
        release_c(0);
        exp_dl = '0;
        @(negedge clk);
        rst_l = 1'b1;
        req(0, 1'b1, 1'b0, 32'd9, '0);

`ifdef MEM_RESP_BOUNDS_EN
        req(0, 1'b0, 1'b1, 32'd40, 32'h0000_0040);
        rb[0] = 32'd16;
        re[0] = 32'd32;
        req(0, 1'b0, 1'b1, 32'd20, 32'h0000_0077);
        req(0, 1'b0, 1'b1, 32'd40, 32'h0000_0088);
        req(0, 1'b1, 1'b0, 32'd40, '0);
        rb[0] = 32'd0;
        re[0] = 32'hFFFF_FFFF;
        req(0, 1'b1, 1'b0, 32'd40, '0);
        req(0, 1'b1, 1'b0, 32'd20, '0);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_handle_responder.md
Name: mem_handle_responder

Overview:
- Memory-side responder for the mem_handle request protocol used by the FPU compute blocks.
- Holds a word-addressed on-chip parameter/gradient store and serves NUM_CLIENTS initiator ports through a round-robin arbiter.
- Each client requests with avail plus r_en or w_en. The responder answers with a single-cycle done pulse and, for reads, data_load.
- Sits between the FPU units (parameter update, matmul and similar) and the memory.

Parameters:
- NUM_CLIENTS, 4, number of initiator ports (1..8).
- WIDTH, 32, data word width in bits.
- DEPTH, 1024, number of words in the store.
- LATENCY, 1, access cycles before the response (1..15).

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset, asynchronous, active-low.
- client_avail  in  NUM_CLIENTS  per-client request valid.
- client_r_en  in  NUM_CLIENTS  read request.
- client_w_en  in  NUM_CLIENTS  write request.
- client_ptr  in  NUM_CLIENTS x 32  word address.
- client_data_store  in  NUM_CLIENTS x WIDTH  write data.
- client_region_begin  in  NUM_CLIENTS x 32  inclusive region start.
- client_region_end  in  NUM_CLIENTS x 32  exclusive region end.
- client_done  out  NUM_CLIENTS  one-cycle completion pulse.
- client_err  out  NUM_CLIENTS  one-cycle error pulse, coincident with done.
- data_load  out  WIDTH  read data, broadcast to all clients, valid while any done is high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset rst_l is asynchronous, active-low.
- Reset values: client_done=0, client_err=0, data_load=0, busy=0, state=IDLE, rr_ptr=0, cooldown mask=0. Memory contents are not reset.
- Request eligibility: client i is eligible when avail[i] & (r_en[i] | w_en[i]) & ~cooldown[i].
  - avail with neither r_en nor w_en set is ignored.
  - If both r_en and w_en are set, the request is a write.
- Client obligations: hold ptr and data_store stable from request until done. The responder latches them at grant regardless.
- States:
  - IDLE:
    - Clear cooldown.
    - If any client is eligible, grant the first eligible index at or after rr_ptr, wrapping modulo NUM_CLIENTS.
    - Latch idx, op, ptr and data; set rr_ptr=idx+1 (wrapping); load cnt=LATENCY-1; go to BUSY.
  - BUSY:
    - Decrement cnt while cnt!=0.
    - When cnt==0, perform the access and go to RESP.
    - Write: mem[ptr]<=data.
    - Read: data_load<=mem[ptr].
  - RESP:
    - client_done[idx]=1 for exactly this cycle; all other done bits are 0.
    - Set cooldown[idx]; go to IDLE.
    - In the following IDLE cycle client idx is not eligible, so its still-high avail is not re-served. It is served again one cycle later if still requesting.
- Latency: a request seen in IDLE at cycle t produces done at t+1+LATENCY. Minimum spacing between back-to-back responses to one client is LATENCY+3 cycles.
- Out-of-range accesses (ptr >= DEPTH):
  - Read returns data_load=0; write is dropped.
  - done and err pulse together.
- data_load holds its last read value between reads; a write does not change it.
- Request withdrawn (avail dropped in BUSY): the access still completes and done still pulses.
- Reset mid-operation: return to IDLE immediately. A write whose BUSY-final edge had not yet occurred is not committed.
- Simultaneous requests: round-robin fairness. With all NUM_CLIENTS requesting continuously, each is served once per NUM_CLIENTS grants.

Optional Feature:
- MEM_RESP_BOUNDS_EN defined:
  - At grant, check region_begin <= ptr < region_end for the granted client.
  - On violation: no memory access, data_load unchanged, done and err pulse at normal latency.
- Not defined: region ports are ignored; err is set only for ptr >= DEPTH.

Test Plan:
- Single write/read, LATENCY=1:
  - Client0 writes 0x3F800000 to ptr 5 at cycle t -> done[0] at t+2.
  - Client0 then reads ptr 5 -> done[0] with data_load=0x3F800000, err=0.
- Round-robin: clients 0, 1 and 2 all request reads at once from rr_ptr=0 -> done order 0,1,2; each done pulse is exactly 1 cycle; no client is served twice.
- Cooldown: client1 holds avail with r_en across its done -> second done arrives exactly LATENCY+3 cycles after the first; never earlier.
- Boundaries:
  - Read of ptr=DEPTH -> data_load=0, done and err together.
  - Write to ptr=DEPTH+7 -> memory unchanged (readback of ptr 7 unaffected).
  - Both r_en and w_en set -> treated as write.
- Reset mid-operation, LATENCY=4: assert rst_l low in the second BUSY cycle of a write to ptr 9 -> busy=0 and done=0 immediately; a later read of ptr 9 returns its old value.
- With MEM_RESP_BOUNDS_EN, region [16,32):
  - Write ptr 40 -> done and err, memory unchanged.
  - Write ptr 20 -> done, err=0.
